// File: rtl/sales_pkg.sv
// Shared types and helpers for the sales statistics scheduler.
package sales_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 32;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/sales_div.sv
// W-bit restoring divider: one quotient bit per cycle, done pulses on the W-th step.
// quotient is the final value while done is high.
module sales_div import sales_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_rem, r_q, r_d;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_rem_sh, w_diff;
  logic          w_ge;
  logic [W-1:0]  w_q_nx;

  // A non-negative trial difference means the divisor fits this bit.
  always_comb begin
    w_rem_sh = {r_rem, r_q[W-1]};
    w_diff   = w_rem_sh - {1'b0, r_d};
    w_ge     = ~w_diff[W];
    w_q_nx   = {r_q[W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_rem <= '0;
      r_q   <= dividend;
      r_d   <= divisor;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_rem <= w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign quotient = w_q_nx;
  assign done     = (r_cnt == CW'(1));
endmodule

// File: rtl/sales_sched.sv
// Round-robin scheduler feeding one shared totals/average datapath.
// Optional SALES_SCHED_SATURATE_EN: saturating arithmetic with sticky ovf.
module sales_sched import sales_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_price,
  input  logic [N_REQ*W-1:0] req_num,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       avg,
  output logic               avg_valid,
  output logic [W-1:0]       total_num,
  output logic [W-1:0]       total_amount,
  output logic               busy,
  output logic               ovf
);
  localparam int IW = $clog2(N_REQ);

  state_t       r_state, w_next;
  logic [IW-1:0] r_last, w_gnt, w_scan;
  logic          w_found, w_hs;
  logic [W-1:0]  r_price, r_num, r_tot_num, r_tot_amt, r_avg;
  logic          r_avg_valid;
  logic [W-1:0]  w_amt, w_new_num, w_new_amt, w_quot;
  logic          w_div_start, w_div_done;

  // Scan starts one past the last grant so every port gets its turn.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_last;
    w_scan  = r_last;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = IW'(rr_next(int'(w_scan), N_REQ));
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_gnt   = w_scan;
      end
    end
  end

  assign w_hs = (r_state == IDLE) && w_found && !rst;

  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_gnt] = 1'b1;
  end

`ifdef SALES_SCHED_SATURATE_EN
  logic [2*W-1:0] w_prod;
  logic [W:0]     w_sum_num, w_sum_amt;
  logic           w_sat, r_ovf;

  always_comb begin
    w_prod    = (2*W)'(r_price) * (2*W)'(r_num);
    w_amt     = (|w_prod[2*W-1:W]) ? '1 : w_prod[W-1:0];
    w_sum_num = {1'b0, r_tot_num} + {1'b0, r_num};
    w_sum_amt = {1'b0, r_tot_amt} + {1'b0, w_amt};
    w_new_num = w_sum_num[W] ? '1 : w_sum_num[W-1:0];
    w_new_amt = w_sum_amt[W] ? '1 : w_sum_amt[W-1:0];
    w_sat     = (|w_prod[2*W-1:W]) | w_sum_num[W] | w_sum_amt[W];
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_ovf <= 1'b0;
    else if (r_state == ACCUM && w_sat)   r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`else
  always_comb begin
    w_amt     = r_price * r_num;
    w_new_num = r_tot_num + r_num;
    w_new_amt = r_tot_amt + w_amt;
  end
  assign ovf = 1'b0;
`endif

  assign w_div_start = (r_state == ACCUM) && (w_new_num != '0);

  sales_div #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend (w_new_amt),
    .divisor  (w_new_num),
    .quotient (w_quot),
    .done     (w_div_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = ACCUM;
      ACCUM:   w_next = (w_new_num == '0) ? DONE : DIV;
      DIV:     if (w_div_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= IW'(N_REQ - 1);
      r_price     <= '0;
      r_num       <= '0;
      r_tot_num   <= '0;
      r_tot_amt   <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_avg_valid <= (w_next == DONE);
      if (w_hs) begin
        r_price <= req_price[w_gnt*W +: W];
        r_num   <= req_num[w_gnt*W +: W];
        r_last  <= w_gnt;
      end
      if (r_state == ACCUM) begin
        r_tot_num <= w_new_num;
        r_tot_amt <= w_new_amt;
        if (w_new_num == '0) r_avg <= '0;
      end
      if (r_state == DIV && w_div_done) r_avg <= w_quot;
    end
  end

  assign avg          = r_avg;
  assign avg_valid    = r_avg_valid;
  assign total_num    = r_tot_num;
  assign total_amount = r_tot_amt;
  assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_sales_sched.sv
// Directed + randomized bench for sales_sched against an order-level reference model.
module tb_sales_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_price = '0;
  logic [N*W-1:0] req_num = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   avg, total_num, total_amount;
  logic           avg_valid, busy, ovf;

  sales_sched #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_price(req_price),
    .req_num(req_num), .req_ready(req_ready), .avg(avg), .avg_valid(avg_valid),
    .total_num(total_num), .total_amount(total_amount), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: running totals kept at order granularity.
  logic [W-1:0] m_num, m_amt;
  logic         m_ovf;
  int           m_last;
  logic [N-1:0] tb_pend;
  logic [W-1:0] tb_price [N];
  logic [W-1:0] tb_num   [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_num = '0; m_amt = '0; m_ovf = 1'b0; m_last = N - 1; tb_pend = '0;
  endtask

  task automatic model_order(input logic [W-1:0] p, input logic [W-1:0] n);
    logic [63:0] prod, s;
    logic [W-1:0] a;
    prod = {32'b0, p} * {32'b0, n};
`ifdef SALES_SCHED_SATURATE_EN
    if (prod > 64'hFFFF_FFFF) begin a = '1; m_ovf = 1'b1; end
    else a = prod[W-1:0];
    s = {32'b0, m_num} + {32'b0, n};
    if (s > 64'hFFFF_FFFF) begin m_num = '1; m_ovf = 1'b1; end
    else m_num = s[W-1:0];
    s = {32'b0, m_amt} + {32'b0, a};
    if (s > 64'hFFFF_FFFF) begin m_amt = '1; m_ovf = 1'b1; end
    else m_amt = s[W-1:0];
`else
    a = prod[W-1:0];
    m_num = m_num + n;
    m_amt = m_amt + a;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("ready_in_reset", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    chk("rst_avg", avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_total_num", total_num, 0);
    chk("rst_total_amount", total_amount, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Serve every pending requester; called at a negedge with the DUT idle.
  task automatic run_batch();
    int g;
    logic [N-1:0] expg;
    while (tb_pend != '0) begin
      for (int i = 0; i < N; i++) begin
        req_price[i*W +: W] = tb_price[i];
        req_num[i*W +: W]   = tb_num[i];
      end
      req_valid = tb_pend;
      #1;
      g = pick(tb_pend, m_last);
      expg = N'(1 << g);
      chk("grant", req_ready, expg);
      @(negedge clk);
      tb_pend[g] = 1'b0;
      req_valid = tb_pend;
      chk("accum_busy", busy, 1);
      chk("accum_ready", req_ready, 0);
      model_order(tb_price[g], tb_num[g]);
      m_last = g;
      if (m_num == '0) begin
        @(negedge clk);
        chk("zero_avg_valid", avg_valid, 1);
        chk("zero_avg", avg, 0);
        chk("zero_total_num", total_num, m_num);
        chk("zero_total_amount", total_amount, m_amt);
      end else begin
        @(negedge clk);
        chk("total_num", total_num, m_num);
        chk("total_amount", total_amount, m_amt);
        chk("div_avg_valid", avg_valid, 0);
        chk("div_ready", req_ready, 0);
        repeat (W - 1) @(negedge clk);
        chk("early_avg_valid", avg_valid, 0);
        @(negedge clk);
        chk("avg_valid", avg_valid, 1);
        chk("avg", avg, m_amt / m_num);
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_avg_valid", avg_valid, 0);
      chk("ovf", ovf, m_ovf);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] p, input logic [W-1:0] n);
    tb_pend[i] = 1'b1;
    tb_price[i] = p;
    tb_num[i] = n;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin tb_price[i] = '0; tb_num[i] = '0; end
    model_reset();

    // Two back-to-back single orders: averages 10 then 12.
    do_reset();
    set_req(0, 32'd10, 32'd3);
    run_batch();
    chk("t1_avg", avg, 32'd10);
    set_req(1, 32'd20, 32'd1);
    run_batch();
    chk("t2_avg", avg, 32'd12);
    chk("t2_total_amount", total_amount, 32'd50);

    // All requesters at once: rotation 0,1,2,3.
    do_reset();
    set_req(0, 32'd4, 32'd1);
    set_req(1, 32'd8, 32'd1);
    set_req(2, 32'd12, 32'd1);
    set_req(3, 32'd16, 32'd1);
    run_batch();
    chk("rr_final_avg", avg, 32'd10);

    // Zero quantity as the first order.
    do_reset();
    set_req(0, 32'd5, 32'd0);
    run_batch();
    chk("zq_total_num", total_num, 0);

    // Product overflow.
    do_reset();
    set_req(0, 32'h8000_0000, 32'd2);
    run_batch();

    // Reset in the 5th DIV cycle, with req2 waiting behind the aborted order.
    do_reset();
    req_price[0 +: W] = 32'd7;
    req_num[0 +: W]   = 32'd9;
    req_valid = 4'b0001;
    #1;
    chk("mr_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    req_price[2*W +: W] = 32'd3;
    req_num[2*W +: W]   = 32'd2;
    repeat (5) @(negedge clk);
    chk("mr_div_busy", busy, 1);
    chk("mr_div_ready", req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_total_num", total_num, 0);
    chk("mr_total_amount", total_amount, 0);
    chk("mr_avg_valid", avg_valid, 0);
    rst = 1'b0;
    model_reset();
    set_req(2, 32'd3, 32'd2);
    set_req(0, 32'd11, 32'd4);
    run_batch();
    chk("mr_after_avg_valid", avg_valid, 0);

    // Randomized batches over the running totals.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      int mask;
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, $urandom, $urandom_range(0, 3));
          else
            set_req(i, $urandom_range(0, 5000), $urandom_range(0, 50));
        end
      end
      run_batch();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/sales_sched.md
# sales_sched

Round-robin scheduler that shares one sales-statistics datapath between several cashier requesters. Each cashier submits an order (unit price, quantity) over a valid/ready handshake. The block accumulates the running totals and computes the weighted average price with a multi-cycle iterative divider. It sits between the cashier front-ends and the reporting logic, and replaces per-cashier single-cycle averaging with one shared, sequenced datapath.

## Interface
Parameters:
- N_REQ, 4, number of requester ports (2..8)
- W, 32, data width of price, quantity, totals and average

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  N_REQ  requester i has an order pending
- req_price  in  N_REQ*W  unit price; slice i is bits [i*W +: W]
- req_num  in  N_REQ*W  quantity; slice i is bits [i*W +: W]
- req_ready  out  N_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both high
- avg  out  W  last computed average price
- avg_valid  out  1  one-cycle pulse when avg is updated
- total_num  out  W  accumulated quantity
- total_amount  out  W  accumulated price*quantity
- busy  out  1  high whenever state is not IDLE
- ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- The FSM has four states: IDLE, ACCUM, DIV, DONE.
- IDLE:
  - Grant goes to the first i with req_valid[i], searching from (last_grant+1) mod N_REQ.
  - req_ready[i] is driven combinationally in IDLE, only for the granted i, and is 0 in every other state.
  - On handshake, latch price and num, record last_grant = i, and go to ACCUM.
- ACCUM:
  - Compute amount = price*num truncated to W bits.
  - Update total_num += num and total_amount += amount, both modulo 2^W.
  - If the new total_num == 0, go to DONE with result 0. Otherwise start the divider on (new total_amount, new total_num) and go to DIV.
- DIV:
  - W cycles of restoring division; the quotient is floor(total_amount/total_num).
  - On the divider's done signal, go to DONE.
- DONE:
  - avg takes the quotient (or 0) and avg_valid = 1 for this cycle only.
  - Return to IDLE.
- Orders with num = 0 are accepted normally: totals are unchanged and avg is recomputed and pulsed.
- Requests still pending while busy simply wait. Ordering is strictly round-robin, and no requester waits more than N_REQ-1 other orders.
- Requesters must hold price, num and valid stable until the handshake completes.

## Timing
- Reset values:
  - avg, total_num, total_amount, ovf, avg_valid, busy: 0
  - req_ready: 0 during the reset cycle
  - state: IDLE
  - last_grant: N_REQ-1, so requester 0 has first priority
- Latency: for a handshake in cycle T, ACCUM is T+1, DIV is T+2..T+W+1, and DONE (avg_valid=1, new avg visible) is T+W+2.
- Zero-total path: DONE is at T+2.
- Throughput: one order per W+3 cycles. The next grant can occur in the cycle after DONE.
- total_num and total_amount update at the end of ACCUM, so they are visible from T+2.
- Reset mid-operation: rst in any state abandons the division, clears all totals, and returns to IDLE. Any in-flight order is lost and avg_valid does not pulse.
- Simultaneous valid on all ports: grants proceed in rotation, one per cycle of IDLE.

## Configuration
- SALES_SCHED_SATURATE_EN
  - Defined: the product and both accumulations saturate at 2^W-1 instead of wrapping. Any saturation event sets ovf, which stays high until rst.
  - Undefined: all arithmetic wraps modulo 2^W and ovf is tied to 0.

## Structure
- Package sales_pkg:
  - state enum (IDLE, ACCUM, DIV, DONE)
  - default N_REQ and W constants
  - round-robin next-index helper function
- Sub-module sales_div: W-bit iterative restoring divider.
  - Ports: clk, rst, start, dividend, divisor, quotient, done.
  - Behaviour: one quotient bit per cycle, done pulses after W cycles.
  - It never sees divisor 0; the zero-total path bypasses it.

## Test plan
- Reset, then req0 price=10 num=3 → ready[0] the same cycle, avg=10 with avg_valid at T+W+2, total_num=3, total_amount=30.
- Then req1 price=20 num=1 → avg=12, total_num=4, total_amount=50.
- req0..req3 all valid just after reset, each num=1 with prices 4, 8, 12, 16 → grants in order 0,1,2,3 spaced W+3 cycles apart; final avg=10.
- First order price=5 num=0 → avg=0 with avg_valid at T+2, divider never started, totals stay 0.
- Order price=0x8000_0000 num=2:
  - Without the macro → total_amount=0, avg=0, ovf=0.
  - With the macro → total_amount=0xFFFF_FFFF, avg=0x7FFF_FFFF, ovf=1.
- rst asserted in the 5th DIV cycle → next cycle state IDLE, totals 0, no avg_valid, and a pending req2 is granted only after req0's priority turn.
